// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported, fixed-latency memory between instruction fetch and data ports.
// Latency: grants are combinational; read data returns RD_LATENCY cycles after the grant.
// Backpressure: data wins by default; a fetch that loses MAX_WAIT times in a row is forced through.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_WAIT   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic {
        ST_NORMAL       = 1'b0,
        ST_FETCH_URGENT = 1'b1
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    state_t                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    // Owner tag per in-flight read: 1 = fetch, 0 = data.
    logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LATENCY-1:0] tag_own_q, tag_own_d;

    // Arbitration and starvation tracking; grants are forced low while in reset.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        if (rst) begin
            case (state_q)
                ST_NORMAL: begin
                    d_gnt = d_req;
                    i_gnt = i_req & ~d_req;
                    if (!i_req || i_gnt) begin
                        wait_cnt_d = 4'd0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        // Fetch has lost enough times; it wins next cycle if still asking.
                        state_d    = ST_FETCH_URGENT;
                        wait_cnt_d = 4'd0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end
                ST_FETCH_URGENT: begin
                    // A fetch that gave up here leaves the slot to data.
                    i_gnt      = i_req;
                    d_gnt      = d_req & ~i_req;
                    state_d    = ST_NORMAL;
                    wait_cnt_d = 4'd0;
                end
                default: begin
                    state_d    = ST_NORMAL;
                    wait_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // Memory command mux from the granted port; idle bus is all zero.
    always_comb begin
        m_req   = i_gnt | d_gnt;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (d_gnt) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (i_gnt) begin
            m_addr  = i_addr;
        end
    end

    // Tag pipeline: new read enters stage 0, everything shifts every cycle without stalls.
    always_comb begin
        tag_vld_d    = '0;
        tag_own_d    = '0;
        tag_vld_d[0] = m_req & ~m_we;
        tag_own_d[0] = i_gnt;
        for (int k = 1; k < RD_LATENCY; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_own_d[k] = tag_own_q[k-1];
        end
    end

    // State, wait counter and tag registers; reset drops any reads in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_NORMAL;
            wait_cnt_q <= 4'd0;
            tag_vld_q  <= '0;
            tag_own_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            tag_vld_q  <= tag_vld_d;
            tag_own_q  <= tag_own_d;
        end
    end

    // Return routing: last tag stage selects the owner, memory data passes straight through.
    always_comb begin
        i_rvalid = tag_vld_q[RD_LATENCY-1] &  tag_own_q[RD_LATENCY-1];
        d_rvalid = tag_vld_q[RD_LATENCY-1] & ~tag_own_q[RD_LATENCY-1];
        i_rdata  = i_rvalid ? m_rdata : '0;
        d_rdata  = d_rvalid ? m_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int RD_LAT = 2;
    localparam int MAXW   = 3;
    localparam int NCYC   = 1800;

    typedef enum int {M_FETCH, M_CONT, M_STLD, M_ABANDON, M_RAND} mode_t;

    typedef struct {
        bit          own_i;
        logic [31:0] data;
        int          due;
    } ret_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LATENCY(RD_LAT), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Memory macro: 16 words, unwritten words read as addr+0x100, fixed read latency.
    bit [31:0] mem_val [16];
    bit [15:0] mem_wr;
    bit [31:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (m_req && m_we) begin
            mem_val[m_addr[5:2]] <= m_wdata;
            mem_wr[m_addr[5:2]]  <= 1'b1;
        end
        if (m_req && !m_we)
            rd_pipe[0] <= mem_wr[m_addr[5:2]] ? mem_val[m_addr[5:2]] : (m_addr + 32'h100);
        else
            rd_pipe[0] <= 32'hBAD0BAD0;
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    assign m_rdata = rd_pipe[RD_LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: consecutive fetch losses, forced-fetch flag, expected returns.
    int          losses;
    bit          urgent;
    ret_t        rq[$];
    bit [31:0]   sh_val [16];
    bit [15:0]   sh_wr;

    function automatic logic [31:0] sh_read(input logic [31:0] a);
        return sh_wr[a[5:2]] ? sh_val[a[5:2]] : (a + 32'h100);
    endfunction

    function automatic bit rst_low(input int n);
        return (n < 3) || (n >= 40 && n < 43) || (n >= 600 && n < 603) || (n >= 1200 && n < 1203);
    endfunction

    function automatic mode_t mode_of(input int n);
        if (n < 40)  return M_FETCH;
        if (n < 100) return M_CONT;
        if (n < 104) return M_STLD;
        if (n < 160) return M_ABANDON;
        return M_RAND;
    endfunction

    initial begin
        bit          exp_i, exp_d, exp_ir, exp_dr;
        logic [31:0] exp_rd;
        bit          i_want, d_want, new_we;
        mode_t       md;

        rst = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        losses = 0; urgent = 1'b0; sh_wr = '0;
        exp_i = 1'b0; exp_d = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            // Expected grants from the arbitration rules.
            exp_i = rst && i_req && (urgent || !d_req);
            exp_d = rst && d_req && !exp_i;
            exp_ir = 1'b0; exp_dr = 1'b0; exp_rd = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                exp_ir = rq[0].own_i;
                exp_dr = !rq[0].own_i;
                exp_rd = rq[0].data;
                void'(rq.pop_front());
            end
            check("i_gnt",    32'(i_gnt),    32'(exp_i));
            check("d_gnt",    32'(d_gnt),    32'(exp_d));
            check("m_req",    32'(m_req),    32'(exp_i | exp_d));
            check("m_we",     32'(m_we),     32'(exp_d & d_we));
            check("m_addr",   m_addr,        exp_d ? d_addr : (exp_i ? i_addr : 32'h0));
            if (!exp_i) check("m_wdata", m_wdata, exp_d ? d_wdata : 32'h0);
            check("i_rvalid", 32'(i_rvalid), 32'(exp_ir));
            check("i_rdata",  i_rdata,       exp_ir ? exp_rd : 32'h0);
            check("d_rvalid", 32'(d_rvalid), 32'(exp_dr));
            check("d_rdata",  d_rdata,       exp_dr ? exp_rd : 32'h0);

            @(posedge clk);
            #1;
            // Advance the model with what was accepted this cycle.
            if (rst) begin
                if (exp_d && d_we) begin
                    sh_val[d_addr[5:2]] = d_wdata;
                    sh_wr[d_addr[5:2]]  = 1'b1;
                end else if (exp_d) begin
                    rq.push_back('{own_i: 1'b0, data: sh_read(d_addr), due: cyc + RD_LAT});
                end else if (exp_i) begin
                    rq.push_back('{own_i: 1'b1, data: sh_read(i_addr), due: cyc + RD_LAT});
                end
                if (urgent) begin
                    urgent = 1'b0;
                    losses = 0;
                end else if (i_req && exp_d) begin
                    losses++;
                    if (losses == MAXW) begin
                        urgent = 1'b1;
                        losses = 0;
                    end
                end else begin
                    losses = 0;
                end
            end

            // Reset schedule for the next cycle; asserting it drops everything in flight.
            if (rst_low(cyc + 1)) begin
                rst = 1'b0;
                rq.delete();
                losses = 0;
                urgent = 1'b0;
            end else begin
                rst = 1'b1;
            end

            // Stimulus for the next cycle.
            md = mode_of(cyc + 1);
            new_we = 1'b0;
            case (md)
                M_FETCH:   begin i_want = 1'b1; d_want = 1'b0; end
                M_CONT:    begin i_want = 1'b1; d_want = 1'b1; end
                M_ABANDON: begin i_want = !urgent; d_want = 1'b1; end
                M_STLD:    begin i_want = 1'b0; d_want = (cyc + 1 == 100) || (cyc + 1 == 101); end
                default: begin
                    i_want = (i_req && !exp_i) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 6);
                    d_want = (d_req && !exp_d) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 5);
                    new_we = ($urandom_range(0, 2) == 0);
                end
            endcase
            if (i_want && (!i_req || exp_i))
                i_addr = 32'($urandom_range(0, 15)) << 2;
            if (md == M_FETCH && cyc + 1 < 8)
                i_addr = 32'(cyc + 1 - 3) << 2;
            if (d_want && (!d_req || exp_d)) begin
                d_addr  = 32'($urandom_range(0, 15)) << 2;
                d_we    = new_we;
                d_wdata = $urandom;
            end
            if (md == M_STLD) begin
                d_addr  = 32'h20;
                d_we    = (cyc + 1 == 100);
                d_wdata = 32'hDEADBEEF;
            end
            i_req = i_want;
            d_req = d_want;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
